pixel_stream_reader: RTL and testbench
======================================

# pixel_stream_reader

Read-side master for the data memory's 8-bit pixel port. On a start command it walks a linear range of pixel addresses, drives `pixel_address`, and captures the returned `pixel` bytes. It delivers them as a valid/ready byte stream with a last-marker. It sits between the data memory (encrypted image, banks 0–3; decrypted image, banks 4–7) and downstream consumers such as the display or UART transmitter.

## Interface
Parameters:
- `N`, 32, address width; matches the data memory address width.
- `CW`, 19, pixel-count width; covers 4 banks × 65536 pixels.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: command strobe; sampled only in IDLE.
- `base_address` in N: first pixel address; latched on an accepted start.
- `pixel_count` in CW: number of pixels to read; latched on an accepted start.
- `pixel_address` out N: to the data memory pixel port.
- `pixel` in 8: from the data memory pixel port; valid one cycle after `pixel_address` is presented (synchronous read).
- `out_data` out 8: stream byte.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready from the consumer.
- `out_last` out 1: high with the final byte of a command.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - `start`=1 with `pixel_count`≠0: latch base and count, go to RUN.
  - `start`=1 with `pixel_count`=0: pulse `done` next cycle, stay IDLE, emit no data.
- **RUN**, issuing reads:
  - A read is issued in a cycle when `fifo_count + inflight − pop < 2`, where `pop = out_valid & out_ready`.
  - An issued read drives `pixel_address` = current address, sets `inflight` for one cycle, increments the address, and decrements `remaining`.
  - After issuing the read with `remaining`=1, go to DRAIN.
- **Data path**
  - An in-flight read captures `pixel` into a 2-entry FIFO the following cycle.
  - The FIFO head drives `out_data` and `out_valid`.
  - Each entry carries a last flag, set for the read issued with `remaining`=1.
- **DRAIN**: no new issues. When the FIFO is empty and nothing is in flight, go to IDLE and assert `done` for exactly that first IDLE cycle.
- `start` while busy is ignored; the latched parameters do not change.
- **Address arithmetic**
  - Unsigned add of 1, modulo 2^N; 0xFFFFFFFF wraps to 0x00000000.
  - Bank crossings (e.g. 0x0000FFFF → 0x00010000) need no special handling.
- `pixel_address` holds its last issued value in non-issue cycles. Redundant reads are harmless.
- **Stream rules**
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - No byte is dropped or duplicated.
  - Bytes arrive in address order.
- Simultaneous capture and pop in the same cycle is legal; occupancy stays the same.

## Timing
- **Reset values**: `pixel_address`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0. The FIFO and the in-flight flag clear, and the state is IDLE.
- **Reset mid-operation**
  - Aborts the command the next cycle. No `done` pulse.
  - Any in-flight `pixel` is discarded.
- **Start latency** (start accepted at edge E0):
  - `busy`=1 from the cycle after E0.
  - First `pixel_address` is presented in cycle 1.
  - First `out_valid` is in cycle 3.
- **Throughput**: with `out_ready` held high, 1 byte per cycle sustained. A count of K completes with the last handshake in cycle K+2.
- **Backpressure**: with `out_ready` low, at most 2 bytes are buffered. Issue stalls when 2 entries are committed; no read is issued whose data has no slot.
- **Completion**
  - `done` pulses the cycle after the final handshake.
  - `busy` is 0 in that same cycle.
  - A new `start` is accepted in the `done` cycle.

## Test plan
- **Basic read**: memory bytes at 0x00000000..3 = 0x10,0x11,0x12,0x13; start count 4, ready=1 → `out_data` 10,11,12,13 in cycles 3–6; `out_last` only with 0x13; `done` in cycle 7; `busy` low in cycle 7.
- **Bank crossing and wrap**
  - base 0x0000FFFE, count 4 → `pixel_address` sequence FFFE, FFFF, 10000, 10001; bytes match bank 0 then bank 1 contents.
  - base 0xFFFFFFFF, count 2 → addresses FFFFFFFF then 00000000.
- **Backpressure**: count 8, `out_ready` low for cycles 3–9, then high → at most 2 reads outstanding; `out_data` stable while stalled; all 8 bytes in order, no duplicates.
- **Random ready**: count 300, `out_ready` random 50% → the scoreboard matches 300 bytes; `out_last` exactly once, on byte 300; exactly one `done`.
- **Zero count and ignored start**
  - count 0 → `done` pulse the next cycle, `out_valid` never 1.
  - `start` pulsed mid-RUN with different parameters → ignored, original stream intact.
- **Reset mid-RUN**: `rst` asserted at cycle 4 of a count-10 read → next cycle `busy`=0, `out_valid`=0, `pixel_address`=0, no `done`; a subsequent start behaves as in the basic read test.

Source files
------------

// File: rtl/pixel_stream_reader.sv
`default_nettype none
//==============================================================================
// Module   : pixel_stream_reader
// Brief    : Read-side master for the data memory 8-bit pixel port. On start,
//            walks base_address .. base_address+pixel_count-1 with synchronous
//            reads and delivers the returned bytes as a valid/ready stream with
//            a last marker. A 2-entry FIFO absorbs consumer backpressure; reads
//            are only issued when a FIFO slot is guaranteed for their data.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start              - command strobe (sampled in IDLE only)
//            base_address[N]    - first pixel address
//            pixel_count[CW]    - number of pixels (0 = immediate done)
//            pixel_address[N]   - address to the memory pixel port
//            pixel[8]           - read data, one cycle after pixel_address
//            out_data/valid/ready/last - output byte stream
//            busy               - command in progress
//            done               - one-cycle completion pulse
// Revision : 1.0 - initial release
//==============================================================================
module pixel_stream_reader #(
    parameter int N  = 32,
    parameter int CW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  base_address,
    input  logic [CW-1:0] pixel_count,
    output logic [N-1:0]  pixel_address,
    input  logic [7:0]    pixel,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_RUN     = 2'd1;
    localparam logic [1:0]    S_DRAIN   = 2'd2;
    localparam logic [N-1:0]  C_ADDR_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_CNT_ZERO = '0;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [N-1:0]    r_addr;          // next address to issue
    logic [N-1:0]    r_addr_held;     // last issued address
    logic [CW-1:0]   r_remaining;
    logic            r_inflight;
    logic            r_inflight_last;
    logic [1:0][8:0] r_fifo;          // {last, data}
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            r_done;

    logic            w_pop;
    logic [2:0]      w_occ_next;
    logic            w_issue;
    logic            w_accept;
    logic            w_zero_cmd;
    logic            w_done_next;

    // Occupancy after this cycle: committed entries plus the read in flight,
    // minus the byte leaving now. Issuing only while this is below 2 means
    // every issued read already owns a FIFO slot.
    assign w_pop      = out_valid & out_ready;
    assign w_occ_next = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == S_RUN) && (w_occ_next < 3'd2);
    assign w_accept   = (r_state == S_IDLE) && start && (pixel_count != C_CNT_ZERO);
    assign w_zero_cmd = (r_state == S_IDLE) && start && (pixel_count == C_CNT_ZERO);

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
                w_done_next = w_zero_cmd;
            end
            S_RUN: begin
                if (w_issue && (r_remaining == C_CNT_ONE)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_occ_next == 3'd0) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_done          <= 1'b0;
            r_addr          <= '0;
            r_addr_held     <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo          <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if (w_accept) begin
                r_addr      <= base_address;
                r_remaining <= pixel_count;
            end else if (w_issue) begin
                r_addr      <= r_addr + C_ADDR_ONE;   // wraps modulo 2^N
                r_addr_held <= r_addr;
                r_remaining <= r_remaining - C_CNT_ONE;
            end

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == C_CNT_ONE);

            // Read data returns the cycle after issue; capture it then.
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= {r_inflight_last, pixel};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Present the live address only on an issue cycle so the port otherwise
    // holds the last issued address.
    assign pixel_address = w_issue ? r_addr : r_addr_held;
    assign out_valid     = (r_count != 2'd0);
    assign out_data      = r_fifo[r_rd_ptr][7:0];
    assign out_last      = out_valid & r_fifo[r_rd_ptr][8];
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_reader.sv
`default_nettype none
//==============================================================================
// Module   : tb_pixel_stream_reader
// Brief    : Directed self-checking bench for pixel_stream_reader with a
//            synchronous-read memory model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pixel_stream_reader;

    localparam int N  = 32;
    localparam int CW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  base_address;
    logic [CW-1:0] pixel_count;
    logic [N-1:0]  pixel_address;
    logic [7:0]    pixel;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pixel_stream_reader #(.N(N), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_address  (base_address),
        .pixel_count   (pixel_count),
        .pixel_address (pixel_address),
        .pixel         (pixel),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    // Memory contents: low byte + 0x10, with bank bits folded in so that
    // bank 0 and bank 1 hold different values. Address 0..3 -> 0x10..0x13.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] + 8'h10 + {a[17:16], 6'b000000};
    endfunction

    always @(posedge clk) pixel <= mem_byte(pixel_address);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // mode 0: ready high; 1: ready low cycles 3..9; 2: random ready;
    // 3: ready high with a conflicting start pulsed in cycle 2.
    task automatic run_cmd(input string name, input logic [31:0] base,
                           input logic [CW-1:0] cnt, input int mode);
        int         nbytes   = 0;
        int         nlast    = 0;
        int         ndone    = 0;
        int         done_cyc = -1;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic       pl = 1'b0;
        logic [7:0] pd = 8'h00;
        logic [31:0] a;
        @(posedge clk); #1;
        start        = 1'b1;
        base_address = base;
        pixel_count  = cnt;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            case (mode)
                1:       out_ready = !(cyc >= 3 && cyc <= 9);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && cyc == 2) begin
                start        = 1'b1;
                base_address = 32'h0000_0500;
                pixel_count  = 19'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1)
                chk({name, " busy@1"}, 32'(busy), 32'(cnt != '0));
            if ((mode == 0 || mode == 3) && cyc <= int'(cnt))
                chk({name, " addr"}, pixel_address, base + 32'(cyc) - 32'd1);
            if (mode == 1 && cyc >= 3 && cyc <= 9)
                chk({name, " addr stall"}, pixel_address, base + 32'd1);
            if (pv && !pr) begin
                chk({name, " hold valid"}, 32'(out_valid), 32'd1);
                chk({name, " hold data"}, 32'(out_data), 32'(pd));
                chk({name, " hold last"}, 32'(out_last), 32'(pl));
            end
            if (out_valid && out_ready) begin
                a = base + 32'(nbytes);
                chk({name, " data"}, 32'(out_data), 32'(mem_byte(a)));
                chk({name, " last"}, 32'(out_last), 32'(nbytes == int'(cnt) - 1));
                if (mode == 0 || mode == 3)
                    chk({name, " byte cycle"}, 32'(cyc), 32'(nbytes + 3));
                nbytes++;
                if (out_last) nlast++;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                chk({name, " busy@done"}, 32'(busy), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        chk({name, " byte count"}, 32'(nbytes), 32'(cnt));
        chk({name, " last count"}, 32'(nlast), 32'(cnt != '0));
        chk({name, " done seen"}, 32'(ndone), 32'd1);
        if (mode == 0)
            chk({name, " done cycle"}, 32'(done_cyc), (cnt == '0) ? 32'd1 : 32'(cnt) + 32'd3);
        @(negedge clk);
        chk({name, " done one-shot"}, 32'(done), 32'd0);
        chk({name, " idle valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        base_address = '0;
        pixel_count  = '0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset addr",  pixel_address, 32'd0);
        chk("reset data",  32'(out_data), 32'd0);
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset last",  32'(out_last), 32'd0);
        chk("reset busy",  32'(busy), 32'd0);
        chk("reset done",  32'(done), 32'd0);
        rst = 1'b0;

        run_cmd("basic",   32'h0000_0000, 19'd4,   0);
        run_cmd("bank",    32'h0000_FFFE, 19'd4,   0);
        run_cmd("wrap",    32'hFFFF_FFFF, 19'd2,   0);
        run_cmd("bp",      32'h0000_0100, 19'd8,   1);
        run_cmd("random",  32'h0002_0000, 19'd300, 2);
        run_cmd("zero",    32'h0000_0040, 19'd0,   0);
        run_cmd("ignore",  32'h0000_0300, 19'd6,   3);

        // Reset during RUN: start count 10, assert rst in cycle 4.
        @(posedge clk); #1;
        start        = 1'b1;
        base_address = 32'h0000_0000;
        pixel_count  = 19'd10;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid busy",  32'(busy), 32'd0);
        chk("rstmid valid", 32'(out_valid), 32'd0);
        chk("rstmid addr",  pixel_address, 32'd0);
        chk("rstmid done",  32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid no done",  32'(done), 32'd0);
            chk("rstmid no valid", 32'(out_valid), 32'd0);
        end

        run_cmd("after rst", 32'h0000_0000, 19'd4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
